// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive/transmit buffers and the receiver.
package uart_pkg;
   localparam int UART_DATA_W    = 8;
   localparam int UART_MAX_DEPTH = 255;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrapping FIFO index: steps 0..DEPTH-1 and wraps to 0, so any depth works,
// not only powers of two.
module uart_fifo_ptr
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;

   // next index: hold, advance, or wrap from the last slot back to zero
   always_comb begin
      idx_d = idx_q;
      if (inc) begin
         if (idx_q == LAST) idx_d = '0;
         else               idx_d = idx_q + 1'b1;
      end
   end

   // index register with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end

   assign idx = idx_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte FIFO between the UART receiver and its consumer, with fill
// level, almost-full for flow control and sticky overrun/framing flags.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int BUFFER_DEPTH = 4,
   parameter int ALMOST_FULL  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rxReady,
   input  logic [UART_DATA_W-1:0] rxData,
   input  logic                   rxFrameErr,
   output logic                   dataValid,
   output logic [UART_DATA_W-1:0] dataOut,
   input  logic                   dataAck,
   output logic [7:0]             count,
   output logic                   full,
   output logic                   almostFull,
   output logic                   overrun,
   output logic                   frameErr,
   input  logic                   clearFlags
);

   localparam int         IDX_W   = $clog2(BUFFER_DEPTH);
   localparam logic [7:0] DEPTH_C = 8'(BUFFER_DEPTH);
   localparam logic [7:0] AF_C    = 8'(ALMOST_FULL);

   uart_byte_t       mem_q [BUFFER_DEPTH];
   uart_byte_t       mem_d [BUFFER_DEPTH];
   logic [7:0]       count_q, count_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic [IDX_W-1:0] head, tail;
   logic             push, pop, drop;

   assign dataValid  = (count_q != 8'd0);
   assign full       = (count_q == DEPTH_C);
   assign almostFull = (count_q >= AF_C);
   assign dataOut    = mem_q[tail];
   assign count      = count_q;
   assign overrun    = overrun_q;
   assign frameErr   = frame_err_q;

   // A full buffer still accepts a byte when the consumer pops on the same edge.
   assign pop  = dataAck && dataValid;
   assign push = rxReady && !rxFrameErr && (!full || pop);
   assign drop = rxReady && !rxFrameErr && full && !pop;

   uart_fifo_ptr #(.DEPTH(BUFFER_DEPTH), .IDX_W(IDX_W)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .idx   (head)
   );

   uart_fifo_ptr #(.DEPTH(BUFFER_DEPTH), .IDX_W(IDX_W)) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .idx   (tail)
   );

   // next storage, fill level and sticky flags; flag set beats clear
   always_comb begin
      mem_d       = mem_q;
      count_d     = count_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (push) mem_d[head] = rxData;

      case ({push, pop})
         2'b10:   count_d = count_q + 8'd1;
         2'b01:   count_d = count_q - 8'd1;
         default: count_d = count_q;
      endcase

      if (drop)            overrun_d = 1'b1;
      else if (clearFlags) overrun_d = 1'b0;

      if (rxReady && rxFrameErr) frame_err_d = 1'b1;
      else if (clearFlags)       frame_err_d = 1'b0;
   end

   // storage is not reset; it is only visible through dataOut while dataValid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // count and flags with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= 8'd0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: two instances (depth 4 and depth 3) share one set
// of inputs; each is tracked by a queue-based reference model.
module tb_uart_rx_buffer;

   localparam int DA = 4, AFA = 3;
   localparam int DB = 3, AFB = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_ready = 1'b0, rx_frame_err = 1'b0, data_ack = 1'b0, clear_flags = 1'b0;
   logic [7:0] rx_data = 8'h00;

   logic       valid_a, full_a, af_a, ovr_a, frm_a;
   logic [7:0] dout_a, count_a;
   logic       valid_b, full_b, af_b, ovr_b, frm_b;
   logic [7:0] dout_b, count_b;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       ova = 1'b0, fra = 1'b0, ovb = 1'b0, frb = 1'b0;

   always #5 clk = ~clk;

   uart_rx_buffer #(.BUFFER_DEPTH(DA), .ALMOST_FULL(AFA)) dut_a (
      .clk(clk), .rst_n(rst_n), .rxReady(rx_ready), .rxData(rx_data),
      .rxFrameErr(rx_frame_err), .dataValid(valid_a), .dataOut(dout_a),
      .dataAck(data_ack), .count(count_a), .full(full_a), .almostFull(af_a),
      .overrun(ovr_a), .frameErr(frm_a), .clearFlags(clear_flags)
   );

   uart_rx_buffer #(.BUFFER_DEPTH(DB), .ALMOST_FULL(AFB)) dut_b (
      .clk(clk), .rst_n(rst_n), .rxReady(rx_ready), .rxData(rx_data),
      .rxFrameErr(rx_frame_err), .dataValid(valid_b), .dataOut(dout_b),
      .dataAck(data_ack), .count(count_b), .full(full_b), .almostFull(af_b),
      .overrun(ovr_b), .frameErr(frm_b), .clearFlags(clear_flags)
   );

   // Expected status vector {count, valid, full, almostFull, overrun, frameErr}
   function automatic logic [12:0] exp_vec(input int n, input int dep, input int af,
                                           input logic ov, input logic fr);
      return {8'(n), (n != 0), (n == dep), (n >= af), ov, fr};
   endfunction

   // Drive one clock edge, advance both reference models, sample 1 ns after the edge.
   task automatic step(input logic rdy, input logic [7:0] d, input logic fe,
                       input logic ack, input logic clr);
      logic pa, pb, da, db;
      rx_ready = rdy; rx_data = d; rx_frame_err = fe; data_ack = ack; clear_flags = clr;
      if (!rst_n) begin
         qa.delete(); qb.delete();
         ova = 1'b0; fra = 1'b0; ovb = 1'b0; frb = 1'b0;
      end else begin
         pa = ack && (qa.size() > 0);
         da = rdy && !fe && (qa.size() == DA) && !pa;
         if (pa) void'(qa.pop_front());
         if (rdy && !fe && !da) qa.push_back(d);
         if (da) ova = 1'b1; else if (clr) ova = 1'b0;
         if (rdy && fe) fra = 1'b1; else if (clr) fra = 1'b0;

         pb = ack && (qb.size() > 0);
         db = rdy && !fe && (qb.size() == DB) && !pb;
         if (pb) void'(qb.pop_front());
         if (rdy && !fe && !db) qb.push_back(d);
         if (db) ovb = 1'b1; else if (clr) ovb = 1'b0;
         if (rdy && fe) frb = 1'b1; else if (clr) frb = 1'b0;
      end
      @(posedge clk);
      #1;
      rx_ready = 1'b0; rx_frame_err = 1'b0; data_ack = 1'b0; clear_flags = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      do_reset();
      n_cmp++;
      obs = {count_a, valid_a, full_a, af_a, ovr_a, frm_a};
      if (obs !== 13'h0) begin
         n_bad++; $display("FAIL reset_a: got %h expected %h", obs, 13'h0);
      end
      n_cmp++;
      obs = {count_b, valid_b, full_b, af_b, ovr_b, frm_b};
      if (obs !== 13'h0) begin
         n_bad++; $display("FAIL reset_b: got %h expected %h", obs, 13'h0);
      end
   endtask

   task automatic test_basic_order();
      logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, exp_b[i], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({count_a, af_a, full_a, dout_a} !== {8'd3, 1'b1, 1'b0, 8'h41}) begin
         n_bad++; $display("FAIL basic_fill: got cnt=%0d af=%b full=%b dout=%h expected cnt=3 af=1 full=0 dout=41",
                           count_a, af_a, full_a, dout_a);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (valid_a !== 1'b1 || dout_a !== exp_b[i]) begin
            n_bad++; $display("FAIL basic_read%0d: got valid=%b dout=%h expected valid=1 dout=%h",
                              i, valid_a, dout_a, exp_b[i]);
         end
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      n_cmp++;
      if (valid_a !== 1'b0 || count_a !== 8'd0) begin
         n_bad++; $display("FAIL basic_empty: got valid=%b cnt=%0d expected valid=0 cnt=0", valid_a, count_a);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({count_a, full_a, ovr_a} !== {8'd4, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL overrun_set: got cnt=%0d full=%b ovr=%b expected cnt=4 full=1 ovr=1",
                           count_a, full_a, ovr_a);
      end
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ovr_a !== 1'b1 || count_a !== 8'd4) begin
         n_bad++; $display("FAIL overrun_set_wins: got ovr=%b cnt=%0d expected ovr=1 cnt=4", ovr_a, count_a);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ovr_a !== 1'b0) begin
         n_bad++; $display("FAIL overrun_clear: got %b expected 0", ovr_a);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (valid_a !== 1'b1 || dout_a !== 8'(8'h10 + i)) begin
            n_bad++; $display("FAIL overrun_read%0d: got valid=%b dout=%h expected valid=1 dout=%h",
                              i, valid_a, dout_a, 8'(8'h10 + i));
         end
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      n_cmp++;
      if (valid_a !== 1'b0) begin
         n_bad++; $display("FAIL overrun_drained: got valid=%b expected 0", valid_a);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_b [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({count_a, full_a, ovr_a} !== {8'd4, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL full_pushpop: got cnt=%0d full=%b ovr=%b expected cnt=4 full=1 ovr=0",
                           count_a, full_a, ovr_a);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dout_a !== exp_b[i]) begin
            n_bad++; $display("FAIL full_read%0d: got %h expected %h", i, dout_a, exp_b[i]);
         end
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_frame_err();
      do_reset();
      step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (count_a !== 8'd0 || frm_a !== 1'b1 || valid_a !== 1'b0) begin
         n_bad++; $display("FAIL frame_set: got cnt=%0d frm=%b valid=%b expected cnt=0 frm=1 valid=0",
                           count_a, frm_a, valid_a);
      end
      step(1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (frm_a !== 1'b1) begin
         n_bad++; $display("FAIL frame_set_wins: got %b expected 1", frm_a);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (frm_a !== 1'b0) begin
         n_bad++; $display("FAIL frame_clear: got %b expected 0", frm_a);
      end
   endtask

   task automatic test_wrap_depth3();
      int rd = 0;
      int guard = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i >= 3) begin
            n_cmp++;
            if (valid_b !== 1'b1 || dout_b !== 8'(rd)) begin
               n_bad++; $display("FAIL wrap_read%0d: got valid=%b dout=%h expected valid=1 dout=%h",
                                 rd, valid_b, dout_b, 8'(rd));
            end
            rd++;
         end
         step(1'b1, 8'(i), 1'b0, (i >= 3), 1'b0);
         n_cmp++;
         if (count_b !== 8'((i < 3) ? i + 1 : 3)) begin
            n_bad++; $display("FAIL wrap_count%0d: got %0d expected %0d", i, count_b, (i < 3) ? i + 1 : 3);
         end
      end
      while (valid_b === 1'b1 && guard < 5) begin
         n_cmp++;
         if (dout_b !== 8'(rd)) begin
            n_bad++; $display("FAIL wrap_drain%0d: got %h expected %h", rd, dout_b, 8'(rd));
         end
         rd++; guard++;
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      n_cmp++;
      if (rd != 10) begin
         n_bad++; $display("FAIL wrap_total: got %0d bytes expected 10", rd);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (count_b !== 8'd0 || valid_b !== 1'b0) begin
         n_bad++; $display("FAIL wrap_ack_empty: got cnt=%0d valid=%b expected cnt=0 valid=0", count_b, valid_b);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (count_a !== 8'd3 || frm_a !== 1'b1) begin
         n_bad++; $display("FAIL midrst_pre: got cnt=%0d frm=%b expected cnt=3 frm=1", count_a, frm_a);
      end
      rst_n = 1'b0;
      step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      n_cmp++;
      if ({count_a, valid_a, ovr_a, frm_a} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL midrst_clear: got cnt=%0d valid=%b ovr=%b frm=%b expected all 0",
                           count_a, valid_a, ovr_a, frm_a);
      end
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (count_a !== 8'd1 || dout_a !== 8'hA5) begin
         n_bad++; $display("FAIL midrst_push: got cnt=%0d dout=%h expected cnt=1 dout=a5", count_a, dout_a);
      end
   endtask

   task automatic test_random();
      logic [12:0] obs, exp;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
         obs = {count_a, valid_a, full_a, af_a, ovr_a, frm_a};
         exp = exp_vec(qa.size(), DA, AFA, ova, fra);
         n_cmp++;
         if (obs !== exp || (qa.size() > 0 && dout_a !== qa[0])) begin
            n_bad++; $display("FAIL rand_a cyc%0d: got st=%h dout=%h expected st=%h dout=%h",
                              c, obs, dout_a, exp, (qa.size() > 0) ? qa[0] : dout_a);
         end
         obs = {count_b, valid_b, full_b, af_b, ovr_b, frm_b};
         exp = exp_vec(qb.size(), DB, AFB, ovb, frb);
         n_cmp++;
         if (obs !== exp || (qb.size() > 0 && dout_b !== qb[0])) begin
            n_bad++; $display("FAIL rand_b cyc%0d: got st=%h dout=%h expected st=%h dout=%h",
                              c, obs, dout_b, exp, (qb.size() > 0) ? qb[0] : dout_b);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic_order();
      test_overrun();
      test_full_push_pop();
      test_frame_err();
      test_wrap_depth3();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
